blink_multi_gen: RTL and testbench

- Multi-channel programmable blink/clock-divider generator; successor to the fixed single-bit power-of-two divider.
- Each channel has a runtime-programmable period, high time (duty) and burst count, plus start/enable control and busy/done status.
- Sits between the board clock and LED/strobe outputs; a control FSM or register bank configures it.

---
 rtl/blink_multi_gen_if.sv | 31 +++
 rtl/blink_multi_gen.sv | 147 ++++++++++++++
 tb/tb_blink_multi_gen.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/blink_multi_gen_if.sv
// Bus bundle for blink_multi_gen: per-channel control, config write port and status.
// cfg_we is a single-cycle strobe with no back-pressure. The generator accepts it on every
// clkin edge. cfg_ch values at or above NUM_CH select no channel.
interface blink_multi_gen_if #(
  parameter int NUM_CH      = 4,
  parameter int CNT_WIDTH   = 23,
  parameter int BURST_WIDTH = 8,
  parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic [NUM_CH-1:0]      enable;
  logic [NUM_CH-1:0]      start;
  logic                   cfg_we;
  logic [CH_W-1:0]        cfg_ch;
  logic [CNT_WIDTH-1:0]   cfg_period;
  logic [CNT_WIDTH-1:0]   cfg_high;
  logic [BURST_WIDTH-1:0] cfg_burst;
  logic [NUM_CH-1:0]      clkout;
  logic [NUM_CH-1:0]      busy;
  logic [NUM_CH-1:0]      done;
  logic [NUM_CH-1:0]      state_dbg;

  modport master (
    output enable, start, cfg_we, cfg_ch, cfg_period, cfg_high, cfg_burst,
    input  clkout, busy, done, state_dbg
  );

  modport slave (
    input  enable, start, cfg_we, cfg_ch, cfg_period, cfg_high, cfg_burst,
    output clkout, busy, done, state_dbg
  );
endinterface

// File: rtl/blink_multi_gen.sv
// Multi-channel programmable blink generator. Each channel has its own period, high time
// and burst count, and its own IDLE/RUN FSM. Shadow config is taken up only at run start
// and at period boundaries.
module blink_multi_gen #(
  parameter int                   NUM_CH      = 4,
  parameter int                   CNT_WIDTH   = 23,
  parameter int                   BURST_WIDTH = 8,
  parameter logic [CNT_WIDTH-1:0] DEF_PERIOD  = CNT_WIDTH'((1 << (CNT_WIDTH - 1)) - 1),
  parameter logic [CNT_WIDTH-1:0] DEF_HIGH    = CNT_WIDTH'(1 << (CNT_WIDTH - 2))
) (
  input  logic              clkin,
  input  logic              rst_n,
  blink_multi_gen_if.slave  bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  logic              cfg_in_range;
  logic [NUM_CH-1:0] clkout_v;
  logic [NUM_CH-1:0] busy_v;
  logic [NUM_CH-1:0] done_v;
  logic [NUM_CH-1:0] state_v;

  assign cfg_in_range = (32'(bus.cfg_ch) < NUM_CH);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic                   sh_we;
    logic [CNT_WIDTH-1:0]   sh_p_q;
    logic [CNT_WIDTH-1:0]   sh_h_q;
    logic [BURST_WIDTH-1:0] sh_n_q;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]   act_p_q, act_p_d;
    logic [CNT_WIDTH-1:0]   act_h_q, act_h_d;
    logic [BURST_WIDTH-1:0] act_n_q, act_n_d;
    logic [BURST_WIDTH-1:0] left_q, left_d;
    logic                   clk_q, clk_d;
    logic                   done_q, done_d;
    logic [CNT_WIDTH:0]     cnt_inc;

    assign sh_we = bus.cfg_we && cfg_in_range && (bus.cfg_ch == CH_W'(i));

    always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
        sh_p_q <= DEF_PERIOD;
        sh_h_q <= DEF_HIGH;
        sh_n_q <= '0;
      end else if (sh_we) begin
        sh_p_q <= bus.cfg_period;
        sh_h_q <= bus.cfg_high;
        sh_n_q <= bus.cfg_burst;
      end
    end

    // One extra bit keeps cnt+1 from wrapping when compared against the high time.
    assign cnt_inc = {1'b0, cnt_q} + 1'b1;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      act_p_d = act_p_q;
      act_h_d = act_h_q;
      act_n_d = act_n_q;
      left_d  = left_q;
      clk_d   = clk_q;
      done_d  = 1'b0;
      if (!bus.enable[i]) begin
        state_d = ST_IDLE;
        clk_d   = 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            clk_d = 1'b0;
            if (bus.start[i]) begin
              state_d = ST_RUN;
              cnt_d   = '0;
              act_p_d = sh_p_q;
              act_h_d = sh_h_q;
              act_n_d = sh_n_q;
              left_d  = sh_n_q;
              clk_d   = (sh_h_q != '0);
            end
          end
          ST_RUN: begin
            if (cnt_q != act_p_q) begin
              cnt_d = cnt_inc[CNT_WIDTH-1:0];
              clk_d = (cnt_inc < {1'b0, act_h_q});
            end else if ((act_n_q != '0) && (left_q == BURST_WIDTH'(1))) begin
              state_d = ST_IDLE;
              clk_d   = 1'b0;
              done_d  = 1'b1;
            end else begin
              // Period boundary: the burst bookkeeping uses the count of the period just ended.
              cnt_d   = '0;
              act_p_d = sh_p_q;
              act_h_d = sh_h_q;
              act_n_d = sh_n_q;
              clk_d   = (sh_h_q != '0);
              if (act_n_q != '0) left_d = left_q - 1'b1;
            end
          end
          default: begin
            state_d = ST_IDLE;
            clk_d   = 1'b0;
          end
        endcase
      end
    end

    always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        act_p_q <= DEF_PERIOD;
        act_h_q <= DEF_HIGH;
        act_n_q <= '0;
        left_q  <= '0;
        clk_q   <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        act_p_q <= act_p_d;
        act_h_q <= act_h_d;
        act_n_q <= act_n_d;
        left_q  <= left_d;
        clk_q   <= clk_d;
        done_q  <= done_d;
      end
    end

    assign clkout_v[i] = clk_q;
    assign busy_v[i]   = (state_q == ST_RUN);
    assign done_v[i]   = done_q;
    assign state_v[i]  = state_q;
  end

  assign bus.clkout    = clkout_v;
  assign bus.busy      = busy_v;
  assign bus.done      = done_v;
  assign bus.state_dbg = state_v;
endmodule

// File: tb/tb_blink_multi_gen.sv
// Testbench for blink_multi_gen: hand sequences, table vectors and random traffic, all
// checked against a per-channel position/period reference model.
module tb_blink_multi_gen;
  localparam int NCH = 5;
  localparam int CW  = 8;
  localparam int BW  = 8;
  localparam int DEF_P = 127;
  localparam int DEF_H = 64;

  logic clkin;
  logic rst_n;
  int   checks;
  int   failures;

  blink_multi_gen_if #(.NUM_CH(NCH), .CNT_WIDTH(CW), .BURST_WIDTH(BW)) bus ();

  blink_multi_gen #(.NUM_CH(NCH), .CNT_WIDTH(CW), .BURST_WIDTH(BW)) dut (
    .clkin (clkin),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  // Reference model state, one entry per channel.
  int         m_sp[NCH], m_sh[NCH], m_sn[NCH];
  int         m_ap[NCH], m_ah[NCH], m_an[NCH];
  logic [7:0] m_left[NCH];
  int         m_pos[NCH];
  bit         m_run[NCH];
  bit         m_done[NCH];

  typedef struct {
    int ch;
    bit st;
    bit en;
    bit ck;
    bit bz;
    bit dn;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_sp[c] = DEF_P; m_sh[c] = DEF_H; m_sn[c] = 0;
      m_ap[c] = DEF_P; m_ah[c] = DEF_H; m_an[c] = 0;
      m_left[c] = '0; m_pos[c] = 0; m_run[c] = 0; m_done[c] = 0;
    end
  endtask

  // Position in period counts up to P; output is high while position < high time.
  task automatic model_step();
    for (int c = 0; c < NCH; c++) begin
      m_done[c] = 0;
      if (!bus.enable[c]) begin
        m_run[c] = 0;
      end else if (!m_run[c]) begin
        if (bus.start[c]) begin
          m_run[c] = 1; m_pos[c] = 0;
          m_ap[c] = m_sp[c]; m_ah[c] = m_sh[c]; m_an[c] = m_sn[c];
          m_left[c] = 8'(m_sn[c]);
        end
      end else if (m_pos[c] < m_ap[c]) begin
        m_pos[c]++;
      end else if (m_an[c] != 0 && m_left[c] == 8'd1) begin
        m_run[c] = 0; m_done[c] = 1;
      end else begin
        if (m_an[c] != 0) m_left[c] = m_left[c] - 8'd1;
        m_pos[c] = 0;
        m_ap[c] = m_sp[c]; m_ah[c] = m_sh[c]; m_an[c] = m_sn[c];
      end
    end
    if (bus.cfg_we && int'(bus.cfg_ch) < NCH) begin
      m_sp[bus.cfg_ch] = int'(bus.cfg_period);
      m_sh[bus.cfg_ch] = int'(bus.cfg_high);
      m_sn[bus.cfg_ch] = int'(bus.cfg_burst);
    end
  endtask

  task automatic model_check();
    logic [NCH-1:0] ek, eb, ed;
    for (int c = 0; c < NCH; c++) begin
      ek[c] = m_run[c] && (m_pos[c] < m_ah[c]);
      eb[c] = m_run[c];
      ed[c] = m_done[c];
    end
    chk("model_clkout", 32'(bus.clkout), 32'(ek));
    chk("model_busy", 32'(bus.busy), 32'(eb));
    chk("model_done", 32'(bus.done), 32'(ed));
  endtask

  task automatic tick();
    @(posedge clkin);
    model_step();
    #1;
    model_check();
  endtask

  task automatic cfg_write(input int ch, input int p, input int h, input int n);
    bus.cfg_ch = 3'(ch); bus.cfg_period = CW'(p); bus.cfg_high = CW'(h);
    bus.cfg_burst = BW'(n); bus.cfg_we = 1'b1;
    tick();
    bus.cfg_we = 1'b0;
  endtask

  initial begin
    int         ones, first_rise, rises, dones;
    logic       prev;
    logic [7:0] rc_exp;
    logic [9:0] sb_exp;

    checks = 0; failures = 0;
    rst_n = 1'b0;
    bus.enable = '0; bus.start = '0; bus.cfg_we = 1'b0; bus.cfg_ch = '0;
    bus.cfg_period = '0; bus.cfg_high = '0; bus.cfg_burst = '0;
    model_reset();

    repeat (3) @(posedge clkin);
    #1;
    chk("reset_clkout", 32'(bus.clkout), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    bus.enable = '1;
    tick();

    // Defaults on ch0: period 128 cycles, high for 64.
    bus.start[0] = 1'b1;
    tick();
    bus.start = '0;
    ones = int'(bus.clkout[0]); first_rise = -1; prev = bus.clkout[0];
    for (int k = 1; k < 256; k++) begin
      tick();
      if (k < 128 && bus.clkout[0]) ones++;
      if (bus.clkout[0] && !prev && first_rise < 0) first_rise = k;
      prev = bus.clkout[0];
    end
    chk("default_high_cycles", 32'(ones), 32'd64);
    chk("default_period", 32'(first_rise), 32'd128);

    // Table: ch1 continuous P=3 H=1, then ch2 burst P=1 H=1 N=3 with an ignored restart.
    cfg_write(1, 3, 1, 0);
    cfg_write(2, 1, 1, 3);
    for (int k = 0; k < 8; k++) vecs[k] = '{1, k == 0, 1'b1, (k % 4) == 0, 1'b1, 1'b0};
    vecs[8]  = '{2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 16; i++) begin
      bus.start = '0;
      bus.start[vecs[i].ch] = vecs[i].st;
      bus.enable[vecs[i].ch] = vecs[i].en;
      tick();
      bus.start = '0;
      chk($sformatf("vec%0d_clkout", i), 32'(bus.clkout[vecs[i].ch]), 32'(vecs[i].ck));
      chk($sformatf("vec%0d_busy", i), 32'(bus.busy[vecs[i].ch]), 32'(vecs[i].bz));
      chk($sformatf("vec%0d_done", i), 32'(bus.done[vecs[i].ch]), 32'(vecs[i].dn));
    end

    // Mid-run reconfig of ch1 to P=1 H=2: current period finishes 1000, then constant high.
    bus.enable[1] = 1'b0; tick(); bus.enable[1] = 1'b1;
    cfg_write(1, 3, 1, 0);
    rc_exp = 8'b1111_0001;
    for (int k = 0; k < 8; k++) begin
      if (k == 0) bus.start[1] = 1'b1;
      if (k == 1) begin
        bus.cfg_ch = 3'd1; bus.cfg_period = CW'(1); bus.cfg_high = CW'(2);
        bus.cfg_burst = '0; bus.cfg_we = 1'b1;
      end
      tick();
      bus.start = '0; bus.cfg_we = 1'b0;
      chk($sformatf("reconfig_k%0d", k), 32'(bus.clkout[1]), 32'(rc_exp[k]));
    end

    // Write landing on the boundary edge applies one period later.
    bus.enable[1] = 1'b0; tick(); bus.enable[1] = 1'b1;
    cfg_write(1, 3, 1, 0);
    sb_exp = 10'b00_0001_0001;
    for (int k = 0; k < 10; k++) begin
      if (k == 0) bus.start[1] = 1'b1;
      if (k == 4) begin
        bus.cfg_ch = 3'd1; bus.cfg_period = CW'(1); bus.cfg_high = CW'(0);
        bus.cfg_burst = '0; bus.cfg_we = 1'b1;
      end
      tick();
      bus.start = '0; bus.cfg_we = 1'b0;
      chk($sformatf("same_edge_k%0d", k), 32'(bus.clkout[1]), 32'(sb_exp[k]));
    end

    // Abort ch3 mid-period.
    cfg_write(3, 5, 3, 2);
    bus.start[3] = 1'b1; tick(); bus.start = '0;
    tick(); tick();
    bus.enable[3] = 1'b0;
    tick();
    chk("abort_clkout", 32'(bus.clkout[3]), 32'd0);
    chk("abort_busy", 32'(bus.busy[3]), 32'd0);
    chk("abort_done", 32'(bus.done[3]), 32'd0);
    tick();
    chk("abort_no_done_later", 32'(bus.done[3]), 32'd0);
    bus.enable[3] = 1'b1;

    // Out-of-range write leaves ch4 on defaults.
    cfg_write(6, 0, 0, 1);
    cfg_write(5, 0, 0, 1);
    bus.start[4] = 1'b1; tick(); bus.start = '0;
    chk("oor_ch4_clkout", 32'(bus.clkout[4]), 32'd1);
    repeat (64) tick();
    chk("oor_ch4_low_after_64", 32'(bus.clkout[4]), 32'd0);

    // Async reset in the middle of a ch2 burst, then a fresh full burst.
    bus.start[2] = 1'b1; tick(); bus.start = '0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_clkout", 32'(bus.clkout), 32'd0);
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    chk("async_rst_done", 32'(bus.done), 32'd0);
    model_reset();
    #1 rst_n = 1'b1;
    tick(); tick();
    chk("post_rst_ch2_idle", 32'(bus.busy[2]), 32'd0);
    cfg_write(2, 1, 1, 3);
    bus.start[2] = 1'b1; tick(); bus.start = '0;
    rises = int'(bus.clkout[2]); dones = 0; prev = bus.clkout[2];
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.clkout[2] && !prev) rises++;
      if (bus.done[2]) dones++;
      prev = bus.clkout[2];
    end
    chk("post_rst_burst_pulses", 32'(rises), 32'd3);
    chk("post_rst_burst_done", 32'(dones), 32'd1);

    // Random traffic against the model.
    for (int n = 0; n < 2500; n++) begin
      for (int c = 0; c < NCH; c++) begin
        bus.enable[c] = ($urandom_range(0, 49) != 0);
        bus.start[c]  = ($urandom_range(0, 7) == 0);
      end
      bus.cfg_we     = ($urandom_range(0, 3) == 0);
      bus.cfg_ch     = 3'($urandom_range(0, 7));
      bus.cfg_period = CW'($urandom_range(0, 6));
      bus.cfg_high   = CW'($urandom_range(0, 8));
      bus.cfg_burst  = BW'($urandom_range(0, 3));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
